// File: rtl/babbage_pkg.sv
// Shared constants for the difference-engine polynomial evaluator.
// FSM encodings are plain localparams so legacy tooling can decode them.
package babbage_pkg;

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] OP   = 2'b01;
  localparam logic [1:0] DONE = 2'b10;

  localparam int MAX_ORDER = 7;
  localparam int IDX_W     = 3;

endpackage

// File: rtl/babbage_poly_engine_if.sv
// Coprocessor-side bundle: start/argument, coefficient write port, result/status.
// master drives requests and coefficients; slave is the engine.
interface babbage_poly_engine_if #(
  parameter int W  = 16,
  parameter int NW = 8
);

  logic                           start;
  logic [NW-1:0]                  n_in;
  logic                           ld_we;
  logic [babbage_pkg::IDX_W-1:0]  ld_idx;
  logic [W-1:0]                   ld_data;
  logic                           ready;
  logic                           done_tick;
  logic [W-1:0]                   f;
  logic                           ovf;

  modport master (
    output start, n_in, ld_we, ld_idx, ld_data,
    input  ready, done_tick, f, ovf
  );

  modport slave (
    input  start, n_in, ld_we, ld_idx, ld_data,
    output ready, done_tick, f, ovf
  );

endinterface

// File: rtl/babbage_diff_stage.sv
// One finite-difference register: parallel load, or accumulate its upper neighbour.
// Single-cycle update, no backpressure; carry-out only exists with BABBAGE_OVF_DETECT_EN.
module babbage_diff_stage #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic         add_en,
  input  logic [W-1:0] load_val,
  input  logic [W-1:0] addend,
`ifdef BABBAGE_OVF_DETECT_EN
  output logic         carry,
`endif
  output logic [W-1:0] q
);

  logic [W-1:0] sum_w;

`ifdef BABBAGE_OVF_DETECT_EN
  assign {carry, sum_w} = {1'b0, q} + {1'b0, addend};
`else
  assign sum_w = q + addend;
`endif

  // load wins so a new run always starts from the coefficient set
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q <= '0;
    end else if (load) begin
      q <= load_val;
    end else if (add_en) begin
      q <= sum_w;
    end
  end

endmodule

// File: rtl/babbage_poly_engine.sv
// Difference-engine evaluator of a degree<=ORDER polynomial at n; done_tick n+2 cycles after start.
// start/ld_we are only honoured in IDLE (ready=1); BABBAGE_OVF_DETECT_EN adds the sticky ovf flag.
module babbage_poly_engine
  import babbage_pkg::*;
#(
  parameter int W     = 16,
  parameter int ORDER = 3,
  parameter int NW    = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  babbage_poly_engine_if.slave  bus
);

  logic [1:0]     state;
  logic [NW-1:0]  cnt;
  logic [W-1:0]   f_reg;
  logic           ovf_reg;

  logic [W-1:0]   c_reg [ORDER+1];
  logic [W-1:0]   c_eff [ORDER+1];
  logic [W-1:0]   d_q   [ORDER];
  logic [W-1:0]   d_last;
  logic [W-1:0]   d_all [ORDER+1];
  logic [ORDER:0] wr_hit;

  logic in_idle;
  logic run_start;
  logic step;

  assign in_idle   = (state == IDLE);
  assign run_start = in_idle && bus.start;
  assign step      = (state == OP) && (cnt != '0);

  // A write in the start cycle must reach D, so D loads from the post-write view of C.
  always_comb begin
    wr_hit = '0;
    for (int k = 0; k <= ORDER; k++) begin
      wr_hit[k] = in_idle && bus.ld_we && (bus.ld_idx == IDX_W'(k));
      c_eff[k]  = wr_hit[k] ? bus.ld_data : c_reg[k];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k <= ORDER; k++) c_reg[k] <= '0;
    end else begin
      for (int k = 0; k <= ORDER; k++) begin
        if (wr_hit[k]) c_reg[k] <= bus.ld_data;
      end
    end
  end

  // The top difference is constant during a run.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      d_last <= '0;
    end else if (run_start) begin
      d_last <= c_eff[ORDER];
    end
  end

  always_comb begin
    for (int k = 0; k < ORDER; k++) d_all[k] = d_q[k];
    d_all[ORDER] = d_last;
  end

`ifdef BABBAGE_OVF_DETECT_EN
  wire [ORDER-1:0] carry;
`endif

  for (genvar k = 0; k < ORDER; k++) begin : g_stage
    babbage_diff_stage #(.W(W)) u_stage (
      .clk      (clk),
      .reset_n  (reset_n),
      .load     (run_start),
      .add_en   (step),
      .load_val (c_eff[k]),
      .addend   (d_all[k+1]),
`ifdef BABBAGE_OVF_DETECT_EN
      .carry    (carry[k]),
`endif
      .q        (d_q[k])
    );
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
      f_reg <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            cnt   <= bus.n_in;
            state <= OP;
          end
        end
        OP: begin
          if (cnt != '0) begin
            cnt <= cnt - NW'(1);
          end else begin
            f_reg <= d_all[0];
            state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef BABBAGE_OVF_DETECT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovf_reg <= 1'b0;
    end else if (run_start) begin
      ovf_reg <= 1'b0;
    end else if (step && (|carry)) begin
      ovf_reg <= 1'b1;
    end
  end
`else
  assign ovf_reg = 1'b0;
`endif

  assign bus.ready     = in_idle;
  assign bus.done_tick = (state == DONE);
  assign bus.f         = f_reg;
  assign bus.ovf       = ovf_reg;

endmodule

// File: tb/tb_babbage_poly_engine.sv
// Drives a W=16 and a W=8 engine with identical stimulus; expectations come from a Newton-form model.
module tb_babbage_poly_engine;

`ifdef BABBAGE_OVF_DETECT_EN
  localparam bit OVF_ON = 1'b1;
`else
  localparam bit OVF_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [7:0]  n_in;
  logic        ld_we;
  logic [2:0]  ld_idx;
  logic [15:0] ld_data;

  always #5 clk = ~clk;

  babbage_poly_engine_if #(.W(16), .NW(8)) bus16 ();
  babbage_poly_engine_if #(.W(8),  .NW(8)) bus8 ();

  assign bus16.start   = start;
  assign bus16.n_in    = n_in;
  assign bus16.ld_we   = ld_we;
  assign bus16.ld_idx  = ld_idx;
  assign bus16.ld_data = ld_data;
  assign bus8.start    = start;
  assign bus8.n_in     = n_in;
  assign bus8.ld_we    = ld_we;
  assign bus8.ld_idx   = ld_idx;
  assign bus8.ld_data  = ld_data[7:0];

  babbage_poly_engine #(.W(16), .ORDER(3), .NW(8)) dut16 (
    .clk(clk), .reset_n(reset_n), .bus(bus16)
  );
  babbage_poly_engine #(.W(8), .ORDER(3), .NW(8)) dut8 (
    .clk(clk), .reset_n(reset_n), .bus(bus8)
  );

  int checks   = 0;
  int failures = 0;

  int          r_lat;
  logic [15:0] r_f16;
  logic [7:0]  r_f8;
  logic        r_ovf16;
  logic        r_ovf8;
  logic        r_hs;

  typedef struct packed {
    logic             reload;
    logic [3:0][15:0] c;
    logic [7:0]       n;
    logic [15:0]      f16;
    logic [7:0]       f8;
    logic             ovf8;
  } vec_t;

  localparam logic [3:0][15:0] QUAD  = {16'd0, 16'd4, 16'd5, 16'd5};
  localparam logic [3:0][15:0] CUBIC = {16'd6, 16'd6, 16'd1, 16'd0};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // f(j) differences in Newton form: D_k(j) = sum_i C[k+i] * binom(j,i)
  function automatic longint binom(input int n, input int k);
    longint r = 1;
    if (k > n) return 0;
    for (int i = 0; i < k; i++) r = r * (n - i) / (i + 1);
    return r;
  endfunction

  function automatic longint diff_at(input logic [3:0][15:0] c, input int k, input int j, input int w);
    longint s = 0;
    for (int i = 0; k + i <= 3; i++) s += longint'(c[k+i]) * binom(j, i);
    return s & ((longint'(1) << w) - 1);
  endfunction

  function automatic bit model_ovf(input logic [3:0][15:0] c, input int n, input int w);
    longint mask = (longint'(1) << w) - 1;
    for (int j = 0; j < n; j++)
      for (int k = 0; k < 3; k++)
        if (diff_at(c, k, j, w) + diff_at(c, k + 1, j, w) > mask) return 1'b1;
    return 1'b0;
  endfunction

  task automatic load_c(input logic [3:0][15:0] c);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      ld_we = 1'b1; ld_idx = 3'(k); ld_data = c[k];
    end
    @(negedge clk);
    ld_we = 1'b0;
  endtask

  task automatic start_pulse(input int n);
    @(negedge clk);
    start = 1'b1; n_in = 8'(n);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Entered in the first cycle after start was sampled; inject_at drives ignored inputs mid-run.
  task automatic wait_done(input int inject_at);
    int  cyc  = 1;
    bit  seen = 1'b0;
    bit  hs   = (bus16.ready === 1'b0) && (bus8.ready === 1'b0);
    while (cyc <= 400) begin
      if (cyc == inject_at) begin
        start = 1'b1; n_in = 8'd1; ld_we = 1'b1; ld_idx = 3'd0; ld_data = 16'd99;
      end else if (cyc == inject_at + 1) begin
        start = 1'b0; ld_we = 1'b0;
      end
      if (bus16.done_tick === 1'b1) begin
        seen = 1'b1;
        break;
      end
      if (bus8.done_tick === 1'b1) hs = 1'b0;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0; ld_we = 1'b0;
    r_lat   = seen ? cyc : -1;
    r_f16   = bus16.f;
    r_f8    = bus8.f;
    r_ovf16 = bus16.ovf;
    r_ovf8  = bus8.ovf;
    hs      = hs && (bus8.done_tick === 1'b1);
    @(negedge clk);
    hs = hs && (bus16.done_tick === 1'b0) && (bus8.done_tick === 1'b0)
            && (bus16.ready === 1'b1) && (bus8.ready === 1'b1) && (bus16.f === r_f16);
    r_hs = hs;
  endtask

  task automatic verify(input string nm, input int n, input logic [15:0] f16, input logic [7:0] f8,
                        input logic ovf16, input logic ovf8);
    check({nm, ".lat"},   r_lat,   n + 2);
    check({nm, ".f16"},   r_f16,   f16);
    check({nm, ".f8"},    r_f8,    f8);
    check({nm, ".ovf16"}, r_ovf16, ovf16);
    check({nm, ".ovf8"},  r_ovf8,  ovf8);
    check({nm, ".hs"},    r_hs,    1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    vec_t tbl [7];
    logic [3:0][15:0] rc;
    int   rn;
    int   dt_cnt;

    tbl[0] = '{reload:1'b1, c:QUAD,  n:8'd3,  f16:16'd32,   f8:8'd32,  ovf8:1'b0};
    tbl[1] = '{reload:1'b0, c:QUAD,  n:8'd0,  f16:16'd5,    f8:8'd5,   ovf8:1'b0};
    tbl[2] = '{reload:1'b1, c:CUBIC, n:8'd5,  f16:16'd125,  f8:8'd125, ovf8:1'b0};
    tbl[3] = '{reload:1'b0, c:CUBIC, n:8'd10, f16:16'd1000, f8:8'd232, ovf8:1'b1};
    tbl[4] = '{reload:1'b0, c:CUBIC, n:8'd7,  f16:16'd343,  f8:8'd87,  ovf8:1'b1};
    tbl[5] = '{reload:1'b0, c:CUBIC, n:8'd2,  f16:16'd8,    f8:8'd8,   ovf8:1'b0};
    tbl[6] = '{reload:1'b0, c:CUBIC, n:8'd0,  f16:16'd0,    f8:8'd0,   ovf8:1'b0};

    reset_n = 1'b0; start = 1'b0; n_in = '0; ld_we = 1'b0; ld_idx = '0; ld_data = '0;
    repeat (3) @(negedge clk);
    check("rst.ready", bus16.ready && bus8.ready, 1);
    check("rst.done",  bus16.done_tick | bus8.done_tick, 0);
    check("rst.f16",   bus16.f, 0);
    check("rst.ovf",   bus16.ovf | bus8.ovf, 0);
    reset_n = 1'b1;
    @(negedge clk);
    check("rst.ready_after", bus16.ready, 1);

    for (int i = 0; i < 7; i++) begin
      if (tbl[i].reload) load_c(tbl[i].c);
      start_pulse(int'(tbl[i].n));
      wait_done(-1);
      verify($sformatf("vec%0d", i), int'(tbl[i].n), tbl[i].f16, tbl[i].f8, 1'b0, OVF_ON & tbl[i].ovf8);
    end

    // start and C0 write during OP must both be ignored
    load_c(QUAD);
    start_pulse(20);
    wait_done(3);
    verify("midrun", 20, 16'd865, 8'd97, 1'b0, OVF_ON);
    start_pulse(0);
    wait_done(-1);
    verify("midrun_rb", 0, 16'd5, 8'd5, 1'b0, 1'b0);

    // indices above ORDER must not alias onto real coefficients
    @(negedge clk); ld_we = 1'b1; ld_idx = 3'd4; ld_data = 16'd77;
    @(negedge clk); ld_idx = 3'd7; ld_data = 16'd88;
    @(negedge clk); ld_we = 1'b0;
    start_pulse(3);
    wait_done(-1);
    verify("badidx", 3, 16'd32, 8'd32, 1'b0, 1'b0);

    // write and start in the same cycle: D takes the new value
    @(negedge clk);
    ld_we = 1'b1; ld_idx = 3'd0; ld_data = 16'd42; start = 1'b1; n_in = 8'd0;
    @(negedge clk);
    ld_we = 1'b0; start = 1'b0;
    wait_done(-1);
    verify("wr_start", 0, 16'd42, 8'd42, 1'b0, 1'b0);

    // asynchronous reset mid-run
    load_c(QUAD);
    start_pulse(50);
    repeat (9) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("arst.f16",   bus16.f, 0);
    check("arst.f8",    bus8.f, 0);
    check("arst.ready", bus16.ready && bus8.ready, 1);
    check("arst.done",  bus16.done_tick | bus8.done_tick, 0);
    @(negedge clk);
    reset_n = 1'b1;
    dt_cnt = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus16.done_tick === 1'b1 || bus8.done_tick === 1'b1) dt_cnt++;
    end
    check("arst.no_done",   dt_cnt, 0);
    check("arst.ready_idle", bus16.ready, 1);
    start_pulse(1);
    wait_done(-1);
    verify("arst_rerun", 1, 16'd0, 8'd0, 1'b0, 1'b0);

    // randomized coefficients and arguments against the Newton-form model
    for (int it = 0; it < 31; it++) begin
      for (int k = 0; k < 4; k++)
        rc[k] = (it % 2 == 0) ? 16'($urandom_range(0, 9)) : 16'($urandom);
      rn = (it == 30) ? 255 : int'($urandom_range(0, 24));
      load_c(rc);
      start_pulse(rn);
      wait_done(-1);
      verify($sformatf("rnd%0d", it), rn,
             16'(diff_at(rc, 0, rn, 16)), 8'(diff_at(rc, 0, rn, 8)),
             OVF_ON & model_ovf(rc, rn, 16), OVF_ON & model_ovf(rc, rn, 8));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/babbage_poly_engine.md
Name: babbage_poly_engine

Overview:
- Parametrised difference-engine FSMD. Evaluates an arbitrary polynomial of degree up to ORDER at integer point n, using repeated addition of finite differences only (no multipliers).
- Next generation of the fixed-quadratic engine. Adds a configurable degree, data width and argument width.
- Initial differences are loaded at run time through a small write port and retained across runs.
- Sits beside the datapath as a start/done_tick coprocessor.

Parameters:
- W, 16: data width of every difference register and of result f.
- ORDER, 3: maximum polynomial degree; number of difference registers is ORDER+1 (D0..D_ORDER). Legal range 1..7.
- NW, 8: width of argument n.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  begin evaluation; sampled only in IDLE.
- n_in  in  NW  argument n, captured with start.
- ld_we  in  1  write strobe for an initial difference; honoured only in IDLE.
- ld_idx  in  3  difference index 0..ORDER. Writes with idx > ORDER are ignored.
- ld_data  in  W  value for C[ld_idx]: C0=f(0), C1=Δf(0), … C_ORDER=Δ^ORDER f(0).
- ready  out  1  high in IDLE.
- done_tick  out  1  one-cycle pulse, result valid.
- f  out  W  registered result; holds its value until the next done_tick.
- ovf  out  1  sticky overflow flag (see Optional Feature).

Behaviour:
- Reset (reset_n=0, asynchronous):
  - state=IDLE; C[*], D[*], cnt, f and ovf all cleared to 0.
  - ready=1 once reset is released; done_tick=0.
  - Reset asserted mid-OP aborts the run. No done_tick is issued.
- States: IDLE, OP, DONE (2-bit encoding).
- IDLE:
  - ready=1.
  - ld_we writes C[ld_idx] <= ld_data.
  - If start=1: D[k] <= C[k] for all k, cnt <= n_in, ovf <= 0, go to OP.
  - If ld_we and start are asserted in the same cycle, the write lands first: the loaded D uses the new value.
- OP:
  - If cnt != 0: cnt <= cnt-1 and, simultaneously for all k < ORDER, D[k] <= D[k] + D[k+1], using pre-edge values. D[ORDER] is constant. Stay in OP.
  - If cnt == 0: f <= D[0], go to DONE.
- DONE: done_tick=1 for exactly one cycle, then unconditionally go to IDLE. This differs from the predecessor, which waited in DONE for start to drop.
- Latency: done_tick is high exactly n+2 cycles after the cycle in which start was sampled.
  - n=0 gives 2 cycles and f = C0.
  - Worst case is 2^NW + 1 cycles.
- Arithmetic:
  - Unsigned, modulo 2^W; wrap-around is silent except for ovf.
  - Two's-complement coefficients give correct signed results modulo 2^W.
- Ignored inputs:
  - start and ld_we outside IDLE have no effect.
  - C registers keep their values across runs, so repeated starts need no reload.
- Unused differences: for degree < ORDER, software writes 0 into the unused high C entries.
- default state branch: go to IDLE.

Optional Feature:
- Macro: BABBAGE_OVF_DETECT_EN.
- With the macro defined:
  - Every adder exposes its carry-out.
  - ovf is set if any D[k] addition carries out of W bits in any OP step.
  - ovf is cleared on start and held through DONE and IDLE until the next start.
- Without the macro: no carry logic is built and ovf is tied to 0. The port list is unchanged.

Decomposition:
- Shared package babbage_pkg:
  - state encodings IDLE=2'b00, OP=2'b01, DONE=2'b10;
  - MAX_ORDER=7;
  - the ld_idx width constant.
- One sub-module, babbage_diff_stage: W-bit register with load, add-enable and carry-out.
  - The top generates ORDER of them, plus a plain register for D[ORDER].
  - FSM and counter stay in the top module.

Test Plan:
- Quadratic 2n²+3n+5 (W=16): load C={5,5,4,0}, start n=3 -> done_tick 5 cycles after start, f=32, ovf=0. Rerun n=0 without reload -> f=5 after 2 cycles.
- Cubic n³: load C={0,1,6,6}, start n=5 -> f=125. Then n=10 -> f=1000. Exactly one done_tick per run.
- Wrap (W=8), n³, n=7 -> f=87 (343 mod 256). With BABBAGE_OVF_DETECT_EN ovf=1; without it ovf=0. Next start with n=2 -> ovf cleared, f=8.
- Ignored inputs mid-run: start n=20 with quadratic coefficients; pulse start with n_in=1 and ld_we to C0=99 during OP -> f=865 (2·400+60+5). Read back with n=0 -> f=5, showing the write was ignored.
- Reset mid-OP: start n=50, assert reset_n=0 at cycle 10 -> f=0, ready=1, no done_tick. Start n=1 with C all 0 -> f=0.
